// File: rtl/mtr_drv_nch_if.sv
// Command and bridge-drive bundle between the speed core and the N-channel
// H-bridge driver.
interface mtr_drv_nch_if #(
  parameter int NUM_CH = 2,
  parameter int SPD_W  = 11
);
  logic                    en;
  logic                    estop;
  logic [NUM_CH*SPD_W-1:0] spd;
  logic [NUM_CH-1:0]       rev;
  logic [NUM_CH-1:0]       PWM_frwrd;
  logic [NUM_CH-1:0]       PWM_rev;
  logic [NUM_CH-1:0]       rev_busy;
  logic                    period_strt;

  modport master (
    output en, estop, spd, rev,
    input  PWM_frwrd, PWM_rev, rev_busy, period_strt
  );

  modport slave (
    input  en, estop, spd, rev,
    output PWM_frwrd, PWM_rev, rev_busy, period_strt
  );
endinterface

// File: rtl/mtr_drv_nch.sv
// N-channel H-bridge driver: slew-limited signed-magnitude PWM with
// ramp-down plus dead time on every reversal, global enable and e-stop.
module mtr_drv_nch #(
  parameter int NUM_CH    = 2,
  parameter int SPD_W     = 11,
  parameter int SLEW_STEP = 64,
  parameter int DEAD_CYC  = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  mtr_drv_nch_if.slave bus
);
  typedef enum logic [1:0] {RUN, RAMP_DN, DEAD} state_e;

  localparam logic [SPD_W:0] STEP    = (SPD_W+1)'(SLEW_STEP);
  localparam logic [15:0]    DEAD_LD = 16'(DEAD_CYC);

  logic [SPD_W-1:0]  cnt;
  logic              period_strt;
  logic [NUM_CH-1:0] pwm_f;
  logic [NUM_CH-1:0] pwm_r;
  logic [NUM_CH-1:0] busy;

  // Move cur toward goal by at most STEP, using one extra bit of headroom.
  function automatic logic [SPD_W-1:0] slew(input logic [SPD_W-1:0] cur,
                                            input logic [SPD_W-1:0] goal);
    logic [SPD_W:0] c;
    logic [SPD_W:0] t;
    logic [SPD_W:0] d;
    c = {1'b0, cur};
    t = {1'b0, goal};
    d = (t > c) ? (t - c) : (c - t);
    if (d > STEP) d = STEP;
    return (t > c) ? (cur + d[SPD_W-1:0]) : (cur - d[SPD_W-1:0]);
  endfunction

  assign period_strt = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state;
    state_e           state_nxt;
    logic [SPD_W-1:0] duty;
    logic [SPD_W-1:0] duty_nxt;
    logic [SPD_W-1:0] tgt;
    logic             dir;
    logic             dir_nxt;
    logic             rq;
    logic [15:0]      dead_cnt;
    logic [15:0]      dead_nxt;

    assign rq  = bus.rev[g];
    assign tgt = (bus.en && !bus.estop) ? bus.spd[g*SPD_W +: SPD_W] : '0;

    always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      dir_nxt   = dir;
      dead_nxt  = dead_cnt;
      if (bus.estop) begin
        duty_nxt = '0;
        if (state != RUN) begin
          state_nxt = DEAD;
          dead_nxt  = DEAD_LD;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (period_strt) begin
              if (rq == dir) begin
                duty_nxt = slew(duty, tgt);
              end else if (duty != '0) begin
                state_nxt = RAMP_DN;
              end else begin
                state_nxt = DEAD;
                dead_nxt  = DEAD_LD;
              end
            end
          end
          RAMP_DN: begin
            if (period_strt) begin
              if (rq == dir) begin
                state_nxt = RUN;
                duty_nxt  = slew(duty, tgt);
              end else begin
                duty_nxt = slew(duty, '0);
                if (duty_nxt == '0) begin
                  state_nxt = DEAD;
                  dead_nxt  = DEAD_LD;
                end
              end
            end
          end
          DEAD: begin
            // Expiry wins over a coincident period_strt: no slew this cycle.
            dead_nxt = dead_cnt - 16'd1;
            if (dead_cnt <= 16'd1) begin
              state_nxt = RUN;
              dir_nxt   = rq;
              dead_nxt  = '0;
            end
          end
          default: state_nxt = RUN;
        endcase
      end
    end

    // Compare against the duty/state being loaded so the on-time of a new
    // period starts exactly one clock after period_strt.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state    <= RUN;
        duty     <= '0;
        dir      <= 1'b0;
        dead_cnt <= '0;
        pwm_f[g] <= 1'b0;
        pwm_r[g] <= 1'b0;
        busy[g]  <= 1'b0;
      end else begin
        state    <= state_nxt;
        duty     <= duty_nxt;
        dir      <= dir_nxt;
        dead_cnt <= dead_nxt;
        pwm_f[g] <= (cnt < duty_nxt) & ~dir_nxt & (state_nxt != DEAD);
        pwm_r[g] <= (cnt < duty_nxt) &  dir_nxt & (state_nxt != DEAD);
        busy[g]  <= (state_nxt != RUN);
      end
    end
  end

  assign bus.PWM_frwrd   = pwm_f;
  assign bus.PWM_rev     = pwm_r;
  assign bus.rev_busy    = busy;
  assign bus.period_strt = period_strt;
endmodule
